// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and access-shape helper for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDX,
        WR,
        RESP
    } lsu_state_t;

    // True when the size code is illegal or the offset breaks natural alignment
    function automatic logic is_bad_shape(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian lane extract/extend for loads and lane merge for narrow stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte/halfword; offset 0 is the most significant lane
    always_comb begin
        byte_lane = word_in[7:0];
        case (offset)
            2'd0: byte_lane = word_in[31:24];
            2'd1: byte_lane = word_in[23:16];
            2'd2: byte_lane = word_in[15:8];
            2'd3: byte_lane = word_in[7:0];
            default: byte_lane = word_in[7:0];
        endcase
        half_lane = offset[1] ? word_in[15:0] : word_in[31:16];
    end

    // Right-justify the selected lane and sign- or zero-extend it
    always_comb begin
        load_data = word_in;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: load_data = word_in;
        endcase
    end

    // Drop the low store bits into the addressed lane, keeping the other lanes
    always_comb begin
        merged_word = word_in;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: merged_word[31:24] = store_data[7:0];
                    2'd1: merged_word[23:16] = store_data[7:0];
                    2'd2: merged_word[15:8]  = store_data[7:0];
                    2'd3: merged_word[7:0]   = store_data[7:0];
                    default: merged_word = word_in;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged_word[15:0]  = store_data[15:0];
                else           merged_word[31:16] = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with read-modify-write for narrow stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

    lsu_state_t  state, next_state;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_err;
    logic        word_store;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept     = req_valid && req_ready;
    assign word_store = req_write && (req_size == SZ_WORD);
    assign req_err    = is_bad_shape(req_size, req_addr[1:0])
                     || ({req_addr[31:2], 2'b00} > LAST_WORD);

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .offset      (offset_q),
        .word_in     (mem_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake/memory strobes; strobes are gated so a reset edge never writes memory
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)         next_state = RESP;
                    else if (word_store) next_state = WR;
                    else                 next_state = RD;
                end
            end
            RD: begin
                mem_read   = !rst;
                next_state = RDX;
            end
            RDX: next_state = write_q ? WR : RESP;
            WR: begin
                mem_write  = !rst;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, memory address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q   <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                offset_q   <= req_addr[1:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                write_q    <= req_write;
                wdata_q    <= req_wdata;
                if (req_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    mem_addr <= {req_addr[31:2], 2'b00};
                    if (word_store) mem_wdata <= req_wdata;
                end
            end
            if (state == RDX) begin
                if (write_q) begin
                    mem_wdata <= merged_word;
                end else begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
            end
            if (state == WR) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_LIMIT(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk;
        logic [31:0] exp_word;
    } vec_t;
    vec_t vecs[25];

    // Data memory model: one-cycle read latency, whole-word writes
    logic [31:0] mem [64];
    logic        mem_init;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h80FF7F01;
            mem[63] <= 32'hCAFEF00D;
        end else begin
            if (mem_read) begin
                mem_rdata <= mem[mem_addr[7:2]];
                rd_cnt    <= rd_cnt + 1;
            end
            if (mem_write) begin
                mem[mem_addr[7:2]] <= mem_wdata;
                wr_cnt             <= wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response monitor: pop the scoreboard on every response
    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL strobes_exclusive actual=11 required=not both");
        end
        if (!rst && resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid required=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic drive(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic wait_resp(output int lat);
        bit got;
        got = 0;
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1;
        end
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout actual=none required=resp_valid");
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        int rd0, wr0, lat;
        exp_t e;
        @(negedge clk);
        chk($sformatf("ready_v%0d", idx), {31'b0, req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive(v.wr, v.size, v.uns, v.addr, v.wdata);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        wait_resp(lat);
        chk($sformatf("latency_v%0d", idx), lat, v.lat);
        chk($sformatf("reads_v%0d", idx), rd_cnt - rd0, v.nrd);
        chk($sformatf("writes_v%0d", idx), wr_cnt - wr0, v.nwr);
        if (v.chk) chk($sformatf("memword_v%0d", idx), mem[v.addr[7:2]], v.exp_word);
    endtask

    initial begin
        int lat, c, r0, w0;
        logic seen;

        // wr size uns addr wdata exp_rdata err lat nrd nwr chk exp_word
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h14,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h14,  32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h14,  32'h11223344, 32'h0,        1'b0, 2, 0, 1, 1'b1, 32'h11223344};
        vecs[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h16,  32'h123456AA, 32'h0,        1'b0, 4, 1, 1, 1'b1, 32'h1122AA44};
        vecs[4]  = '{1'b0, SZ_BYTE, 1'b0, 32'h16,  32'h0,        32'hFFFFFFAA, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, SZ_BYTE, 1'b1, 32'h16,  32'h0,        32'h000000AA, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, SZ_WORD, 1'b0, 32'h14,  32'h80011234, 32'h0,        1'b0, 2, 0, 1, 1'b1, 32'h80011234};
        vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h14,  32'h0,        32'hFFFF8001, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, SZ_HALF, 1'b0, 32'h15,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h16,  32'h0,        32'h00001234, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'h16,  32'hFFFFBEEF, 32'h0,        1'b0, 4, 1, 1, 1'b1, 32'h8001BEEF};
        vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h14,  32'h0,        32'h8001BEEF, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, SZ_ILL,  1'b0, 32'h14,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, SZ_WORD, 1'b0, 32'h16,  32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, SZ_BYTE, 1'b0, 32'h00,  32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 32'h03,  32'h0,        32'h00000001, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[18] = '{1'b0, SZ_BYTE, 1'b0, 32'h02,  32'h0,        32'h0000007F, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[19] = '{1'b0, SZ_HALF, 1'b0, 32'h02,  32'h0,        32'h00007F01, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[20] = '{1'b1, SZ_BYTE, 1'b0, 32'h01,  32'hFFFFFF55, 32'h0,        1'b0, 4, 1, 1, 1'b1, 32'h80557F01};
        vecs[21] = '{1'b1, SZ_WORD, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
        vecs[22] = '{1'b1, SZ_BYTE, 1'b0, 32'h13,  32'h000000CC, 32'h0,        1'b0, 4, 1, 1, 1'b1, 32'h000000CC};
        vecs[23] = '{1'b0, SZ_HALF, 1'b1, 32'h12,  32'h0,        32'h000000CC, 1'b0, 3, 1, 0, 1'b0, 32'h0};
        vecs[24] = '{1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        32'hFFFFFFCC, 1'b0, 3, 1, 0, 1'b0, 32'h0};

        rst = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 25; i++) apply(i, vecs[i]);

        // Reset during the write phase of a byte store: no write, no response
        @(negedge clk);
        w0 = wr_cnt;
        r0 = resp_cnt;
        drive(1'b1, SZ_BYTE, 1'b0, 32'h14, 32'h00000077);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (mem_write) seen = 1'b1;
        end
        chk("rstwr_reach_wr_cycle", c, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwr_mem_write_after", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr_no_write", wr_cnt - w0, 0);
        chk("rstwr_word_kept", mem[5], 32'h8001BEEF);
        chk("rstwr_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        chk("rstwr_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("rstwr_no_resp", resp_cnt - r0, 0);

        // Back-to-back requests with req_valid held high
        @(negedge clk);
        r0 = resp_cnt;
        drive(1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0);
        sb.push_back('{32'hCAFEF00D, 1'b0});
        @(posedge clk);
        #1;
        drive(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
        sb.push_back('{32'h8001BEEF, 1'b0});
        c = 0;
        seen = 1'b0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (req_ready) seen = 1'b1;
        end
        chk("b2b_ready_return", c, 4);
        chk("b2b_first_done", resp_cnt - r0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        chk("b2b_second_latency", lat, 3);
        repeat (4) @(negedge clk);
        chk("b2b_each_once", resp_cnt - r0, 2);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_LIMIT, 256, data-memory size in bytes; word-aligned addresses above ADDR_LIMIT-4 are out of range.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  CPU access request present.
REQ-005 req_ready  out  1  unit idle, request accepted when req_valid&&req_ready at rising edge.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid; misaligned, illegal size or out of range.
REQ-014 mem_addr  out  32  word-aligned address to data memory ({addr[31:2],2'b00}).
REQ-015 mem_wdata  out  32  full word to data memory.
REQ-016 mem_read  out  1  data-memory read enable.
REQ-017 mem_write  out  1  data-memory write enable (writes all 4 bytes).
REQ-018 mem_rdata  in  32  data-memory output, valid the cycle after a mem_read cycle.

Function
REQ-019 Memory is big-endian: byte offset 0 occupies bits [31:24], offset 3 bits [7:0]; halfword offset 0 -> [31:16], offset 2 -> [15:0].
REQ-020 FSM states IDLE, RD, RDX, WR, RESP; req_ready=1 only in IDLE.
REQ-021 Accepted request captured into registers (addr, size, unsigned, write, wdata); inputs ignored afterwards.
REQ-022 Error check at accept: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or aligned word address > ADDR_LIMIT-4 -> RESP with resp_err=1, no memory access.
REQ-023 Load: IDLE->RD (mem_read=1)->RDX (extract/extend mem_rdata into resp_rdata)->RESP; resp_valid 3 cycles after accept edge.
REQ-024 Word store: IDLE->WR (mem_write=1, mem_wdata=wdata)->RESP; resp_valid 2 cycles after accept.
REQ-025 Byte/halfword store: read-modify-write IDLE->RD->RDX (merge low 8/16 wdata bits into addressed lane of mem_rdata, other lanes preserved)->WR->RESP; resp_valid 4 cycles after accept.
REQ-026 RESP lasts exactly one cycle then IDLE; next request accepted no earlier than the cycle after RESP.
REQ-027 mem_read and mem_write never both 1; both 0 outside RD/WR; mem_addr held stable from RD through WR.
REQ-028 resp_rdata and resp_err hold their last values outside RESP; consumers sample only when resp_valid=1.

Reset
REQ-029 rst=1 at an edge forces IDLE; resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata all 0 after the edge.
REQ-030 mem_read and mem_write gated by !rst so no memory write occurs on any edge where rst=1, including reset during WR.
REQ-031 Request in flight at reset is dropped without a response; req_ready=1 the cycle after rst deasserts.

Structure
REQ-032 Shared package lsu_pkg holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration.
REQ-033 Combinational lane extract/merge logic in one sub-module lsu_lane_align; FSM and registers in load_store_unit.

Verification
REQ-034 Word store 0xDEADBEEF at 0x14, then word load 0x14 -> one mem_write cycle, resp_rdata=0xDEADBEEF, resp_err=0, latencies 2 and 3.
REQ-035 With 0x14 holding 0x11223344: store byte 0xAA at 0x16 -> memory word 0x1122AA44; signed byte load 0x16 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-036 Halfword load 0x14 signed on 0x8001xxxx -> 0xFFFF8001; halfword load at 0x15 -> resp_err=1, mem_read/mem_write never asserted.
REQ-037 Word load at 0xFC (ADDR_LIMIT=256) -> normal; at 0x100 -> resp_err=1, resp_rdata=0.
REQ-038 rst asserted during WR of a byte store -> no write to memory, target word unchanged, no resp_valid, req_ready=1 after reset.
REQ-039 req_valid held high back-to-back -> req_ready low from accept through RESP, second request accepted the cycle after RESP, each completes once.
